// File: rtl/posit_pkg.sv
// posit_pkg: shared definitions for the posit arithmetic unit.
//   POSIT_N / POSIT_ES : default posit width and exponent field width
//   posit_dec_t        : decoded operand (flags, sign, signed scale, 1.f significand)
//   state_t            : divider FSM states
//   nar()              : Not-a-Real pattern (1 followed by zeros)
package posit_pkg;

  localparam int POSIT_N        = 16;
  localparam int POSIT_ES       = 3;
  localparam int POSIT_FW       = POSIT_N - 3 - POSIT_ES;
  localparam int POSIT_MAXSCALE = (POSIT_N - 2) << POSIT_ES;
  // Signed width that holds +/-maxscale of a single operand.
  localparam int DEC_SCALE_W    = $clog2(POSIT_MAXSCALE + 1) + 1;
  localparam int DEC_SIG_W      = POSIT_FW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_ROUND
  } state_t;

  // Sized for the package default N/ES; the significand is 1.f with the
  // fraction left-aligned and zero-padded to the maximum fraction width.
  typedef struct packed {
    logic                          is_zero;
    logic                          is_nar;
    logic                          sign;
    logic signed [DEC_SCALE_W-1:0] scale;
    logic [DEC_SIG_W-1:0]          sig;
  } posit_dec_t;

  function automatic logic [POSIT_N-1:0] nar(input int n);
    logic [POSIT_N-1:0] r;
    r        = '0;
    r[n-1]   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/posit_decode.sv
// posit_decode: combinational posit field extractor, shared by the divider
// and the multiplier.
//   p_i   : posit pattern
//   dec_o : zero/NaR flags, sign, scale = regime*2^ES + exponent, and the
//           significand 1.f (fraction left-aligned, zero-padded)
module posit_decode
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic [N-1:0] p_i,
  output posit_dec_t   dec_o
);

  localparam int FW = N - 3 - ES;

  logic [N-2:0] body;
  logic [N-4:0] ef;
  int           run;
  int           k;
  int           scale;
  logic         stop;

  always_comb begin
    // Magnitude without the sign bit; NaR maps to 0 here but is flagged.
    body = p_i[N-1] ? (N-1)'(-p_i) : p_i[N-2:0];

    run  = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == body[N-2])) run++;
      else stop = 1'b1;
    end

    k = body[N-2] ? (run - 1) : -run;

    // Bits after the regime terminator, left-aligned. The run is always at
    // least 1, so the first bit after the terminator is body[N-3-run].
    ef = body[N-4:0] << (run - 1);

    scale = k * (1 << ES) + int'(ef[N-4 -: ES]);

    dec_o.is_zero = (p_i == '0);
    dec_o.is_nar  = (p_i == {1'b1, {(N-1){1'b0}}});
    dec_o.sign    = p_i[N-1];
    dec_o.scale   = DEC_SCALE_W'(scale);
    dec_o.sig     = {1'b1, ef[FW-1:0]};
  end

endmodule

// File: rtl/posit_divider.sv
// posit_divider: sequential posit divider, posit = x / y.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; sampled only while busy = 0
//   x, y       : dividend / divisor, captured on an accepted start
//   busy       : operation in progress
//   done       : one-cycle pulse, posit valid from this cycle
//   posit      : quotient, held until the next done
// Flow: IDLE -> PREP (decode, specials) -> DIV (Q restoring steps, one
// quotient bit per clock) -> ROUND (normalise, encode, RNE, saturate).
module posit_divider
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] posit
);

  localparam int FW       = N - 3 - ES;
  localparam int Q        = FW + 3;
  localparam int MAXSCALE = (N - 2) << ES;
  localparam int SW       = DEC_SCALE_W + 1;
  localparam int CW       = $clog2(Q + 1);
  // Encode window: 2 regime seed bits, exponent, fraction, and N bits of
  // headroom so the regime shift never drops bits out of the sticky range.
  localparam int VW       = 2 + ES + (Q - 1) + N;

  state_t               state_q, state_d;
  logic [N-1:0]         x_q, x_d, y_q, y_d;
  logic                 sign_q, sign_d;
  logic signed [SW-1:0] scale_q, scale_d;
  logic [FW:0]          div_q, div_d;
  logic [FW+1:0]        rem_q, rem_d;
  logic [Q-1:0]         quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 special_q, special_d;
  logic                 special_nar_q, special_nar_d;
  logic [N-1:0]         posit_q, posit_d;
  logic                 done_q, done_d;

  posit_dec_t dec_x, dec_y;

  logic                 ge;
  logic [FW+1:0]        sub;
  logic [Q-2:0]         frac_n;
  logic signed [SW-1:0] scale_n;

  posit_decode #(.N(N), .ES(ES)) u_dec_x (.p_i(x_q), .dec_o(dec_x));
  posit_decode #(.N(N), .ES(ES)) u_dec_y (.p_i(y_q), .dec_o(dec_y));

  // Encode sign/scale/fraction as a posit, rounding to nearest-even on the
  // full N-bit pattern and saturating to maxpos/minpos.
  function automatic logic [N-1:0] encode(input logic                 sgn,
                                          input logic signed [SW-1:0] s,
                                          input logic [Q-2:0]         frac,
                                          input logic                 sticky_in);
    int           si, k;
    logic [ES-1:0] e;
    logic [VW-1:0] base, v;
    logic [N-2:0] body, mag;
    logic         guard, sticky;
    si = int'(s);
    if (si > MAXSCALE) begin
      mag = '1;
    end else if (si < -MAXSCALE) begin
      mag = (N-1)'(1);
    end else begin
      k = si >>> ES;
      e = ES'(si);
      // Positive regime: arithmetic shift replicates the leading 1 to give
      // k+1 ones and the 0 terminator. Negative: -k zeros then a 1.
      if (k >= 0) begin
        base = {2'b10, e, frac, {N{1'b0}}};
        v    = $signed(base) >>> k;
      end else begin
        base = {2'b01, e, frac, {N{1'b0}}};
        v    = base >> (-k - 1);
      end
      body   = v[VW-1 -: N-1];
      guard  = v[VW-N];
      sticky = sticky_in | (|v[VW-N-1:0]);
      mag    = body + (N-1)'(guard & (body[0] | sticky));
    end
    return sgn ? -{1'b0, mag} : {1'b0, mag};
  endfunction

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sign_d        = sign_q;
    scale_d       = scale_q;
    div_d         = div_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    special_d     = special_q;
    special_nar_d = special_nar_q;
    posit_d       = posit_q;
    done_d        = 1'b0;

    ge      = (rem_q >= {1'b0, div_q});
    sub     = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    // Quotient is in (0.5, 2); a cleared integer bit means shift by one.
    frac_n  = quo_q[Q-1] ? quo_q[Q-2:0] : {quo_q[Q-3:0], 1'b0};
    scale_n = quo_q[Q-1] ? scale_q : (scale_q - SW'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        special_d     = 1'b0;
        special_nar_d = 1'b0;
        quo_d         = '0;
        cnt_d         = '0;
        if (dec_x.is_nar || dec_y.is_nar || dec_y.is_zero) begin
          special_d     = 1'b1;
          special_nar_d = 1'b1;
          state_d       = ST_ROUND;
        end else if (dec_x.is_zero) begin
          special_d = 1'b1;
          state_d   = ST_ROUND;
        end else begin
          sign_d  = dec_x.sign ^ dec_y.sign;
          scale_d = SW'($signed(dec_x.scale)) - SW'($signed(dec_y.scale));
          rem_d   = {1'b0, dec_x.sig};
          div_d   = dec_y.sig;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        rem_d = sub << 1;
        quo_d = {quo_q[Q-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(Q - 1)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (special_q) posit_d = special_nar_q ? N'(nar(N)) : '0;
        else           posit_d = encode(sign_q, scale_n, frac_n, |rem_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      sign_q        <= 1'b0;
      scale_q       <= '0;
      div_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      special_q     <= 1'b0;
      special_nar_q <= 1'b0;
      posit_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sign_q        <= sign_d;
      scale_q       <= scale_d;
      div_q         <= div_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      special_q     <= special_d;
      special_nar_q <= special_nar_d;
      posit_q       <= posit_d;
      done_q        <= done_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign posit = posit_q;

endmodule
